// File: rtl/clock_route_pkg.sv
// Shared types and helpers for the clock route switch sequencer.
package clock_route_pkg;

  localparam int unsigned MAX_ROUTES = 16;
  localparam int unsigned NUM_ROUTES = 4;
  localparam int unsigned SEL_OFF    = NUM_ROUTES;

  typedef enum logic [1:0] {
    IDLE,
    DIS_WAIT,
    EN_WAIT,
    ERROR
  } seq_state_e;

  // One-hot enable vector for a route index; out-of-range codes yield all-off.
  function automatic logic [MAX_ROUTES-1:0] route_onehot(input logic [4:0] sel);
    route_onehot = '0;
    if (sel < 5'(MAX_ROUTES)) route_onehot[sel[3:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/clock_route_ack_sync.sv
// Multi-flop synchronizer for one asynchronous route acknowledge.
module clock_route_ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) sync_q <= '0;
    else               sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_route_switch_sequencer.sv
// Break-before-make route switch: drop the old enable, wait for its ack to
// fall, then raise the new enable and wait for its ack; every wait is bounded.
module clock_route_switch_sequencer
  import clock_route_pkg::*;
#(
  parameter int unsigned NUM_ROUTES     = clock_route_pkg::NUM_ROUTES,
  parameter int unsigned SEL_W          = $clog2(NUM_ROUTES) + 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  async_resetn,
  input  logic                  req_valid,
  input  logic [SEL_W-1:0]      req_sel,
  output logic                  req_ready,
  output logic [NUM_ROUTES-1:0] route_enable,
  input  logic [NUM_ROUTES-1:0] route_enable_ack,
  output logic [SEL_W-1:0]      active_sel,
  output logic                  active_valid,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clear
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned      IDX_W     = $clog2(NUM_ROUTES);
  localparam logic [SEL_W-1:0] ROUTE_OFF = SEL_W'(NUM_ROUTES);

  seq_state_e            state, state_nxt;
  logic [SEL_W-1:0]      target, target_nxt, active_sel_nxt, en_sel;
  logic                  active_valid_nxt, timeout_err_nxt;
  logic [NUM_ROUTES-1:0] route_enable_nxt, ack_sync;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
  logic                  old_ack, target_ack, expired, req_in_range;

  for (genvar i = 0; i < NUM_ROUTES; i++) begin : g_ack_sync
    clock_route_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
      .clock        (clock),
      .async_resetn (async_resetn),
      .async_in     (route_enable_ack[i]),
      .sync_out     (ack_sync[i])
    );
  end

  // active_sel still names the old route while its ack drains in DIS_WAIT.
  assign old_ack      = ack_sync[active_sel[IDX_W-1:0]];
  assign target_ack   = ack_sync[target[IDX_W-1:0]];
  assign expired      = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign req_in_range = (req_sel < ROUTE_OFF);
  assign en_sel       = (state == IDLE) ? req_sel : target;

  assign req_ready = (state == IDLE);
  assign busy      = (state == DIS_WAIT) || (state == EN_WAIT);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt        = state;
    target_nxt       = target;
    active_sel_nxt   = active_sel;
    active_valid_nxt = active_valid;
    route_enable_nxt = route_enable;
    timeout_err_nxt  = timeout_err;
    wait_cnt_nxt     = wait_cnt + 1'b1;

    case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        if (req_valid && !(active_valid && req_sel == active_sel)) begin
          target_nxt = req_in_range ? req_sel : ROUTE_OFF;
          if (active_valid) begin
            route_enable_nxt = '0;
            active_valid_nxt = 1'b0;
            state_nxt        = DIS_WAIT;
          end else if (req_in_range) begin
            route_enable_nxt = NUM_ROUTES'(route_onehot(5'(en_sel)));
            state_nxt        = EN_WAIT;
          end
        end
      end
      DIS_WAIT: begin
        if (!old_ack) begin
          wait_cnt_nxt = '0;
          if (target < ROUTE_OFF) begin
            route_enable_nxt = NUM_ROUTES'(route_onehot(5'(en_sel)));
            state_nxt        = EN_WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end else if (expired) begin
          state_nxt = ERROR;
        end
      end
      EN_WAIT: begin
        if (target_ack) begin
          active_sel_nxt   = target;
          active_valid_nxt = 1'b1;
          state_nxt        = IDLE;
        end else if (expired) begin
          state_nxt = ERROR;
        end
      end
      ERROR: begin
        wait_cnt_nxt = '0;
        if (err_clear) begin
          timeout_err_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Any timeout lands in the safe all-off state.
    if (state_nxt == ERROR && state != ERROR) begin
      route_enable_nxt = '0;
      active_valid_nxt = 1'b0;
      timeout_err_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state        <= IDLE;
      target       <= '0;
      active_sel   <= '0;
      active_valid <= 1'b0;
      route_enable <= '0;
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      active_sel   <= active_sel_nxt;
      active_valid <= active_valid_nxt;
      route_enable <= route_enable_nxt;
      timeout_err  <= timeout_err_nxt;
      wait_cnt     <= wait_cnt_nxt;
    end
  end

  a_enable_onehot : assert property (@(posedge clock) disable iff (!async_resetn)
    $countones(route_enable) <= 1);

endmodule
